// File: rtl/dmem_pkg.sv
// Shared sizing, port indices and address check for the data-memory arbiter.
package dmem_pkg;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int DEPTH_W = 5;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LOAD = 1'b1
  } port_e;

  // Word-aligned and inside the 2**DEPTH_W word window; anything else is an error access.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr[AW-1:DEPTH_W+2] == '0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles both requester handshakes and the memory-side bus of dmem_arbiter.
interface dmem_arbiter_if #(
  parameter int AW      = dmem_pkg::AW,
  parameter int DW      = dmem_pkg::DW,
  parameter int DEPTH_W = dmem_pkg::DEPTH_W
);

  logic               p0_req;
  logic               p0_we;
  logic [AW-1:0]      p0_addr;
  logic [DW-1:0]      p0_wdata;
  logic               p0_gnt;
  logic               p0_rvalid;
  logic [DW-1:0]      p0_rdata;
  logic               p0_err;

  logic               p1_req;
  logic               p1_we;
  logic [AW-1:0]      p1_addr;
  logic [DW-1:0]      p1_wdata;
  logic               p1_gnt;
  logic               p1_rvalid;
  logic [DW-1:0]      p1_rdata;
  logic               p1_err;

  logic               mem_we;
  logic [DEPTH_W-1:0] mem_addr;
  logic [DW-1:0]      mem_wd;
  logic [DW-1:0]      mem_rd;

  // Requesters plus the memory model sit on the master side.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way grant picker. DMEM_ARB_RR_EN selects round-robin on conflict;
// otherwise port 0 has fixed priority.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  // On conflict the port that did not win last time goes next.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/access controller in front of the 32-word data memory.
// Conflict policy comes from dmem_rr_pick (DMEM_ARB_RR_EN = round-robin).
module dmem_arbiter #(
  parameter int AW      = dmem_pkg::AW,
  parameter int DW      = dmem_pkg::DW,
  parameter int DEPTH_W = dmem_pkg::DEPTH_W
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  import dmem_pkg::*;

  logic [1:0]    req;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic          granted;
  port_e         sel_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_ok;

  port_e         last_gnt;
  logic          resp_valid;
  port_e         resp_port;
  logic          resp_err;
  logic [DW-1:0] resp_data;
  logic          resp_show;

  assign req = {bus.p1_req, bus.p0_req};

  dmem_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // Grant and memory drive are combinational so the access commits at the grant edge.
  always_comb begin
    gnt       = RST ? 2'b00 : pick;
    granted   = |gnt;
    sel_port  = gnt[1] ? PORT_LOAD : PORT_CORE;
    sel_we    = gnt[1] ? bus.p1_we    : bus.p0_we;
    sel_addr  = gnt[1] ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt[1] ? bus.p1_wdata : bus.p0_wdata;
    sel_ok    = addr_ok(sel_addr);

    bus.p0_gnt   = gnt[0];
    bus.p1_gnt   = gnt[1];
    bus.mem_we   = granted & sel_we & sel_ok;
    bus.mem_addr = granted ? sel_addr[DEPTH_W+1:2] : '0;
    bus.mem_wd   = granted ? sel_wdata : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt   <= PORT_CORE;
      resp_valid <= 1'b0;
      resp_port  <= PORT_CORE;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= granted;
      resp_port  <= sel_port;
      resp_err   <= granted & ~sel_ok;
      resp_data  <= (granted & ~sel_we & sel_ok) ? bus.mem_rd : '0;
      if (granted) begin
        last_gnt <= sel_port;
      end
    end
  end

  // A response still in the register while RST is high is dropped, never shown.
  always_comb begin
    resp_show     = resp_valid & ~RST;
    bus.p0_rvalid = resp_show & (resp_port == PORT_CORE);
    bus.p1_rvalid = resp_show & (resp_port == PORT_LOAD);
    bus.p0_rdata  = (resp_show & (resp_port == PORT_CORE)) ? resp_data : '0;
    bus.p1_rdata  = (resp_show & (resp_port == PORT_LOAD)) ? resp_data : '0;
    bus.p0_err    = resp_show & (resp_port == PORT_CORE) & resp_err;
    bus.p1_err    = resp_show & (resp_port == PORT_LOAD) & resp_err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus random bench for dmem_arbiter against a word-array reference model;
// expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

  import dmem_pkg::*;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Memory the arbiter drives; the reference model keeps its own copy.
  logic [31:0] env_mem [32];
  assign bus.mem_rd = env_mem[bus.mem_addr];
  always @(posedge CLK) begin
    if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wd;
  end

  logic [31:0] ref_mem [32];
  int          ref_last;
  logic        req_q [2];
  logic        we_q  [2];
  logic [31:0] addr_q [2];
  logic [31:0] wd_q  [2];
  int          checks;
  int          passed;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    req_q[0] = r0; we_q[0] = w0; addr_q[0] = a0; wd_q[0] = d0;
    req_q[1] = r1; we_q[1] = w1; addr_q[1] = a1; wd_q[1] = d1;
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  function automatic int refWinner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (RR_MODE && last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit refIsErr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd128);
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    int k;
    k = $urandom_range(0, 9);
    a = $urandom_range(0, 31) * 4;
    if (k == 0) a = a + $urandom_range(1, 3);
    if (k == 1) a = a | (32'h80 << $urandom_range(0, 24));
    return a;
  endfunction

  // One clock of traffic: grant/memory drive before the edge, response after it.
  task automatic stepCycle(output int g);
    bit          err;
    bit          we;
    logic [31:0] a;
    logic [31:0] exp_rd;
    err = 1'b0;
    exp_rd = '0;
    g = refWinner(req_q[0], req_q[1], ref_last);
    #2;
    checkOutput("p0_gnt", bus.p0_gnt, g == 0);
    checkOutput("p1_gnt", bus.p1_gnt, g == 1);
    if (g >= 0) begin
      a   = addr_q[g];
      we  = we_q[g];
      err = refIsErr(a);
      checkOutput("mem_we", bus.mem_we, we && !err);
      checkOutput("mem_addr", bus.mem_addr, a[6:2]);
      checkOutput("mem_wd", bus.mem_wd, wd_q[g]);
      exp_rd = (!we && !err) ? ref_mem[a[6:2]] : 32'h0;
      if (we && !err) ref_mem[a[6:2]] = wd_q[g];
      ref_last = g;
    end else begin
      checkOutput("idle_mem_we", bus.mem_we, 0);
      checkOutput("idle_mem_addr", bus.mem_addr, 0);
      checkOutput("idle_mem_wd", bus.mem_wd, 0);
    end
    @(posedge CLK);
    #1;
    checkOutput("p0_rvalid", bus.p0_rvalid, g == 0);
    checkOutput("p1_rvalid", bus.p1_rvalid, g == 1);
    if (g >= 0) begin
      checkOutput("rdata", (g == 0) ? bus.p0_rdata : bus.p1_rdata, exp_rd);
      checkOutput("err", (g == 0) ? bus.p0_err : bus.p1_err, err);
    end
    @(negedge CLK);
  endtask

  task automatic applyReset(input int n);
    RST = 1'b1;
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
    repeat (n) begin
      #2;
      checkOutput("rst_p0_gnt", bus.p0_gnt, 0);
      checkOutput("rst_p1_gnt", bus.p1_gnt, 0);
      checkOutput("rst_mem_we", bus.mem_we, 0);
      @(posedge CLK);
      #1;
      checkOutput("rst_p0_rvalid", bus.p0_rvalid, 0);
      checkOutput("rst_p1_rvalid", bus.p1_rvalid, 0);
      checkOutput("rst_p0_rdata", bus.p0_rdata, 0);
      checkOutput("rst_p1_err", bus.p1_err, 0);
      @(negedge CLK);
    end
    RST = 1'b0;
    ref_last = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          g;
    logic        pr [2];
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [31:0] v;
    checks = 0;
    passed = 0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset with both requesting, then a conflict run of six cycles.
    applyReset(2);
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
    repeat (6) stepCycle(g);

    // Loader writes, core reads the same word on the next cycle.
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    stepCycle(g);
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    stepCycle(g);
    checkOutput("raw_rdata", bus.p0_rdata, 32'hDEADBEEF);

    // Misaligned write and out-of-range read, then confirm word 1 untouched.
    applyStimulus(1, 1, 32'h06, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0);
    stepCycle(g);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h80, 32'h0);
    stepCycle(g);
    applyStimulus(1, 0, 32'h04, 32'h0, 0, 0, 32'h0, 32'h0);
    stepCycle(g);

    // Reset right behind a granted read swallows its response.
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    #2;
    checkOutput("prerst_p0_gnt", bus.p0_gnt, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("rstdrop_p0_rvalid", bus.p0_rvalid, 0);
    @(posedge CLK);
    #1;
    checkOutput("rstdrop2_p0_rvalid", bus.p0_rvalid, 0);
    @(negedge CLK);
    RST = 1'b0;
    ref_last = 0;
    repeat (2) stepCycle(g);

    // Last word of the window.
    applyStimulus(1, 1, 32'h7C, 32'h12345678, 0, 0, 32'h0, 32'h0);
    stepCycle(g);
    applyStimulus(1, 0, 32'h7C, 32'h0, 0, 0, 32'h0, 32'h0);
    stepCycle(g);
    checkOutput("last_word_rdata", bus.p0_rdata, 32'h12345678);
    checkOutput("last_word_err", bus.p0_err, 0);

    // Random traffic; an ungranted request is held unchanged until granted.
    pr[0] = 0;
    pr[1] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pr[p] && $urandom_range(0, 3) != 0) begin
          pr[p] = 1;
          pw[p] = $urandom_range(0, 1);
          pa[p] = randAddr();
          pd[p] = $urandom;
        end
      end
      applyStimulus(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
      stepCycle(g);
      if (g >= 0) pr[g] = 0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and access controller in front of the 32-entry single-port data memory. Port 0 is the core load/store path; port 1 is the program/data loader (testbench or debug injector). The block grants at most one access per cycle, converts byte addresses to word indices, rejects misaligned and out-of-range accesses, and returns registered read data with fixed 1-cycle latency.

Parameters:
AW, 32, requester byte-address width
DW, 32, data width
DEPTH_W, 5, log2 of memory word count (32 words)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
p0_req  in  1  port 0 request
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  AW  port 0 byte address
p0_wdata  in  DW  port 0 write data
p0_gnt  out  1  port 0 request accepted this cycle
p0_rvalid  out  1  port 0 response valid
p0_rdata  out  DW  port 0 read data
p0_err  out  1  port 0 response is an error (valid with p0_rvalid)
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1
mem_we  out  1  memory write enable
mem_addr  out  DEPTH_W  memory word index
mem_wd  out  DW  memory write data
mem_rd  in  DW  memory read data (combinational from mem_addr)

Behaviour:
- Handshake: requester asserts req with we/addr/wdata stable; transfer occurs in the cycle gnt=1. Requester must hold its signals until gnt. gnt is combinational from req and arbiter state.
- Arbitration: at most one gnt per cycle. Only one requester: it wins. Both requesting: round-robin or fixed priority (see Optional Feature).
- last_gnt register (1 bit): updated to the winning port on every grant; reset value 0, so port 1 wins the first simultaneous request.
- Address check at grant: aligned iff addr[1:0]==0; in range iff addr[AW-1:DEPTH_W+2]==0. Failing either is an error access: still granted, mem_we forced 0, no memory state change.
- Memory drive in grant cycle: mem_addr=addr[DEPTH_W+1:2]; mem_wd=wdata; mem_we=we & granted & no error. No grant: mem_we=0, mem_addr/mem_wd=0.
- Response (1 cycle after grant, registered): px_rvalid=1 for exactly one cycle, for reads and writes alike. Read OK: px_rdata=mem_rd sampled at the grant edge. Write or error: px_rdata=0. px_err=1 on error access.
- Throughput: one access per cycle; back-to-back grants to the same or alternating ports are legal, and responses follow in grant order.
- Read-after-write same address on consecutive cycles: the read returns the newly written data, because the write commits at the grant edge.
- Reset: all outputs registered from state clear on the edge with RST=1: p0/p1 rvalid=0, rdata=0, err=0, last_gnt=0. gnt and mem_we are 0 while RST=1. A response pending when RST asserts is discarded and never presented.
- State machine: none beyond last_gnt plus the response pipeline registers (resp_port, resp_valid, resp_data, resp_err).

Optional Feature:
DMEM_ARB_RR_EN. Defined: round-robin; on conflict, grant the port not equal to last_gnt. Undefined: fixed priority; port 0 always wins on conflict, port 1 is granted only when p0_req=0; last_gnt is still maintained but unused.

Decomposition:
- Shared package dmem_pkg: AW, DW, DEPTH_W defaults; port-index constants PORT_CORE=0, PORT_LOAD=1; helper function addr_ok(addr).
- One sub-module is natural: dmem_rr_pick. It takes two req bits and last_gnt and returns a one-hot grant, keeping the arbitration policy and macro selection isolated.

Test Plan:
1. Reset: RST=1 for 2 cycles with both req=1 -> gnt=0, mem_we=0, rvalid=0 throughout; after release, first conflict grants port 1 (RR) or port 0 (no RR).
2. Port 1 writes 0xDEADBEEF to addr 0x10, then port 0 reads 0x10 on the next cycle -> mem_addr=4, mem_we=1 in cycle 1; p0_rvalid=1, p0_rdata=0xDEADBEEF one cycle after port 0's grant.
3. Both ports request continuously for 6 cycles with RR -> grants alternate 1,0,1,0,1,0; without RR -> port 0 granted all 6 and p1_gnt stays 0.
4. Port 0 write to 0x06 (misaligned) and port 1 read of 0x80 (out of range) -> both granted, mem_we=0, px_rvalid=1 with px_err=1 and rdata=0; a readback of 0x04 is unchanged.
5. Port 0 read granted, then RST asserted in the next cycle -> p0_rvalid stays 0; no stale response appears after RST deasserts.
6. Port 0 write to 0x7C (last word) with data 0x12345678 -> mem_addr=31; a subsequent read returns 0x12345678 and err=0.
